// File: rtl/lcd_raster_scanner.sv
// rtl/lcd_raster_scanner.sv - raster coordinate source merging text pixels into a registered RGB565 stream
//
// Walks x_pixel/y_pixel across a WIDTH x HEIGHT frame, samples the text
// generator's combinational reply, and presents text-or-background colour as
// a registered RGB565 pixel with a valid/ready handshake.
//
// Ports:
//   clock, reset_n             clock and asynchronous active-low reset
//   start                      begins a frame from IDLE
//   x_pixel, y_pixel, text_en  coordinate and enable to the text generator
//   text_pixel, text_active    combinational colour/foreground reply
//   pixel_data, pixel_valid    registered output pixel and its valid flag
//   pixel_ready                downstream accept
//   frame_start, frame_done    single-cycle frame boundary pulses
//   busy                       high while scanning or draining the last pixel

module lcd_raster_scanner #(
    parameter int          WIDTH      = 320,
    parameter int          HEIGHT     = 240,
    parameter logic [15:0] BG_COLOUR  = 16'h0000,
    parameter bit          CONTINUOUS = 1'b0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic [8:0]  x_pixel,
    output logic [7:0]  y_pixel,
    output logic        text_en,
    input  logic [15:0] text_pixel,
    input  logic        text_active,
    output logic [15:0] pixel_data,
    output logic        pixel_valid,
    input  logic        pixel_ready,
    output logic        frame_start,
    output logic        frame_done,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_next;

    logic accept;
    logic load;
    logic x_last;
    logic y_last;

    assign accept = pixel_valid && pixel_ready;
    // The output register is free when empty or being emptied this cycle.
    assign load   = (state == SCAN) && (!pixel_valid || pixel_ready);
    assign x_last = (x_pixel == 9'(WIDTH - 1));
    assign y_last = (y_pixel == 8'(HEIGHT - 1));

    assign text_en = (state == SCAN);
    assign busy    = (state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // frame_start/frame_done mark the transition cycle itself, so in
    // continuous mode the end of one frame and start of the next coincide.
    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        frame_done  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next  = SCAN;
                    frame_start = 1'b1;
                end
            end
            SCAN: begin
                if (load && x_last && y_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (accept) begin
                    frame_done = 1'b1;
                    if (CONTINUOUS) begin
                        state_next  = SCAN;
                        frame_start = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Coordinates advance only on a load, so a stalled output also freezes
    // the coordinate the text generator sees. After the last pixel they wrap
    // to 0,0, which is where the next frame begins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_pixel     <= 9'd0;
            y_pixel     <= 8'd0;
            pixel_data  <= 16'd0;
            pixel_valid <= 1'b0;
        end else if (load) begin
            pixel_data  <= text_active ? text_pixel : BG_COLOUR;
            pixel_valid <= 1'b1;
            if (x_last) begin
                x_pixel <= 9'd0;
                y_pixel <= y_last ? 8'd0 : y_pixel + 8'd1;
            end else begin
                x_pixel <= x_pixel + 9'd1;
            end
        end else if (accept) begin
            pixel_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lcd_raster_scanner.sv
// tb/tb_lcd_raster_scanner.sv - self-checking bench for lcd_raster_scanner

module tb_lcd_raster_scanner;

    localparam int AW = 320;
    localparam int AH = 4;
    localparam int AN = AW * AH;
    localparam int BW = 8;
    localparam int BH = 3;
    localparam int BN = BW * BH;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // DUT A: one-shot, BG 16'h001F
    logic        a_reset_n, a_start, a_ten, a_tact, a_valid, a_ready, a_fs, a_fd, a_busy;
    logic [8:0]  a_x;
    logic [7:0]  a_y;
    logic [15:0] a_tpix, a_data;
    int          stub_mode;

    // DUT B: continuous
    logic        b_reset_n, b_start, b_ten, b_tact, b_valid, b_ready, b_fs, b_fd, b_busy;
    logic [8:0]  b_x;
    logic [7:0]  b_y;
    logic [15:0] b_tpix, b_data;

    assign a_tact = (stub_mode == 0) ? (a_x < 9'd8) : 1'b1;
    assign a_tpix = (stub_mode == 0) ? {a_x[7:0], a_y} : {a_y[6:0], a_x};
    assign b_tact = 1'b1;
    assign b_tpix = {4'h1, b_y[3:0], b_x[7:0]};

    lcd_raster_scanner #(.WIDTH(AW), .HEIGHT(AH), .BG_COLOUR(16'h001F), .CONTINUOUS(1'b0)) dut_a (
        .clock(clock), .reset_n(a_reset_n), .start(a_start),
        .x_pixel(a_x), .y_pixel(a_y), .text_en(a_ten),
        .text_pixel(a_tpix), .text_active(a_tact),
        .pixel_data(a_data), .pixel_valid(a_valid), .pixel_ready(a_ready),
        .frame_start(a_fs), .frame_done(a_fd), .busy(a_busy)
    );

    lcd_raster_scanner #(.WIDTH(BW), .HEIGHT(BH), .BG_COLOUR(16'h0000), .CONTINUOUS(1'b1)) dut_b (
        .clock(clock), .reset_n(b_reset_n), .start(b_start),
        .x_pixel(b_x), .y_pixel(b_y), .text_en(b_ten),
        .text_pixel(b_tpix), .text_active(b_tact),
        .pixel_data(b_data), .pixel_valid(b_valid), .pixel_ready(b_ready),
        .frame_start(b_fs), .frame_done(b_fd), .busy(b_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_a(input int mode, input int n);
        int x;
        int y;
        logic [8:0] xv;
        logic [7:0] yv;
        x  = n % AW;
        y  = n / AW;
        xv = x[8:0];
        yv = y[7:0];
        if (mode == 0) return (x < 8) ? {xv[7:0], yv} : 16'h001F;
        return {yv[6:0], xv};
    endfunction

    function automatic logic [15:0] exp_b(input int n);
        int x;
        int y;
        logic [7:0] xv;
        logic [3:0] yv;
        x  = n % BW;
        y  = (n % BN) / BW;
        xv = x[7:0];
        yv = y[3:0];
        return {4'h1, yv, xv};
    endfunction

    logic [15:0] cap [0:2047];
    int          n_xfer, fs_cnt, fd_cnt, bound_err, stable_err, fd_n;
    bit          frame_ok, stall_seen;
    logic [8:0]  fd_prev_x;
    logic [7:0]  fd_prev_y;

    // Runs one frame on DUT A from IDLE, starting at posedge+#1.
    task automatic run_frame(input int rmode, input int stall_at, input int start_at);
        int          cyc;
        int          stall_left;
        bit          holding;
        logic [8:0]  hx, px;
        logic [7:0]  hy, py;
        logic [15:0] hd;
        cyc = 0; stall_left = 0; holding = 0;
        hx = '0; hy = '0; hd = '0; px = '0; py = '0;
        n_xfer = 0; fs_cnt = 0; fd_cnt = 0; bound_err = 0; stable_err = 0;
        fd_n = -1; frame_ok = 0; stall_seen = 0; fd_prev_x = '0; fd_prev_y = '0;
        while (!frame_ok && cyc < 12000) begin
            if (stall_at >= 0 && n_xfer == stall_at && !stall_seen) begin
                stall_left = 5;
                stall_seen = 1;
            end
            if (stall_left > 0)  a_ready = 1'b0;
            else if (rmode == 1) a_ready = 1'($urandom_range(0, 1));
            else                 a_ready = 1'b1;
            a_start = (cyc == 0) || (start_at >= 0 && n_xfer == start_at);
            @(negedge clock);
            if (a_fs) fs_cnt++;
            if (a_x >= 9'(AW) || a_y >= 8'(AH)) bound_err++;
            if (stall_left > 0) begin
                if (holding && (a_data !== hd || a_x !== hx || a_y !== hy || a_valid !== 1'b1))
                    stable_err++;
                hd = a_data; hx = a_x; hy = a_y; holding = 1;
                stall_left--;
            end else begin
                holding = 0;
            end
            if (a_valid && a_ready) begin
                if (n_xfer < 2048) cap[n_xfer] = a_data;
                n_xfer++;
            end
            if (a_fd) begin
                fd_cnt++;
                fd_n = n_xfer;
                fd_prev_x = px;
                fd_prev_y = py;
                frame_ok = 1;
            end
            px = a_x;
            py = a_y;
            @(posedge clock);
            #1;
            cyc++;
        end
        a_start = 1'b0;
        a_ready = 1'b1;
        chk("a_frame_timeout", 64'(frame_ok), 64'd1);
    endtask

    task automatic check_order(input string name, input int mode);
        int bad;
        int first;
        bad = 0;
        first = -1;
        for (int i = 0; i < AN; i++) begin
            if (cap[i] !== exp_a(mode, i)) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d bad pixels, first at transfer %0d got %0h expected %0h",
                     name, bad, first, cap[first], exp_a(mode, first));
        end
    endtask

    typedef struct {
        int          idx;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int          bn, b_fd_cnt, b_coincide, b_bad, b_fd_after;
        bit          b_chk_next, b_busy_after;
        logic [15:0] bcap [0:63];

        vecs[0] = '{0,    16'h0000};
        vecs[1] = '{7,    16'h0700};
        vecs[2] = '{8,    16'h001F};
        vecs[3] = '{320,  16'h0001};
        vecs[4] = '{319,  16'h001F};
        vecs[5] = '{327,  16'h0701};
        vecs[6] = '{643,  16'h0302};
        vecs[7] = '{1279, 16'h001F};

        stub_mode = 0;
        a_reset_n = 1'b0; a_start = 1'b0; a_ready = 1'b1;
        b_reset_n = 1'b0; b_start = 1'b0; b_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("a_reset_state", {a_x, a_y, a_data, a_valid, a_fs, a_fd, a_busy, a_ten}, 64'd0);
        a_reset_n = 1'b1;
        b_reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("a_idle_after_reset", {a_valid, a_busy, a_ten}, 64'd0);

        // Frame 1: text stub, ready always high
        run_frame(0, -1, -1);
        chk("a1_frame_start_cnt", 64'(fs_cnt), 64'd1);
        chk("a1_frame_done_cnt", 64'(fd_cnt), 64'd1);
        chk("a1_transfers", 64'(n_xfer), 64'(AN));
        chk("a1_done_on_last", 64'(fd_n), 64'(AN));
        chk("a1_last_coord", {fd_prev_x, fd_prev_y}, {9'(AW - 1), 8'(AH - 1)});
        chk("a1_bounds", 64'(bound_err), 64'd0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("a1_xfer_%0d", vecs[i].idx), cap[vecs[i].idx], vecs[i].exp);
        end
        check_order("a1_order", 0);
        @(negedge clock);
        chk("a1_idle_after", {a_busy, a_valid, a_ten}, 64'd0);
        @(posedge clock);
        #1;

        // Frame 2: unique-pixel stub, 5-cycle stall at transfer 100
        stub_mode = 1;
        run_frame(0, 100, -1);
        chk("a2_stall_seen", 64'(stall_seen), 64'd1);
        chk("a2_stall_stable", 64'(stable_err), 64'd0);
        chk("a2_transfers", 64'(n_xfer), 64'(AN));
        check_order("a2_order", 1);

        // Frame 3: random ready
        run_frame(1, -1, -1);
        chk("a3_transfers", 64'(n_xfer), 64'(AN));
        chk("a3_bounds", 64'(bound_err), 64'd0);
        chk("a3_frame_done_cnt", 64'(fd_cnt), 64'd1);
        check_order("a3_order", 1);

        // Frame 4: start pulsed mid-frame
        run_frame(0, -1, 700);
        chk("a4_frame_start_cnt", 64'(fs_cnt), 64'd1);
        chk("a4_transfers", 64'(n_xfer), 64'(AN));
        check_order("a4_order", 1);
        @(negedge clock);
        chk("a4_idle_after", {a_busy, a_valid}, 64'd0);

        // DUT B: continuous mode, two frames back to back
        @(posedge clock);
        #1;
        bn = 0; b_fd_cnt = 0; b_coincide = 0; b_chk_next = 0;
        b_start = 1'b1;
        for (int cyc = 0; cyc < 400 && b_fd_cnt < 2; cyc++) begin
            @(negedge clock);
            if (b_chk_next) begin
                chk("b_restart_xy_en", {b_x, b_y, b_ten}, {9'd0, 8'd0, 1'b1});
                b_chk_next = 0;
            end
            if (b_valid && b_ready) begin
                if (bn < 64) bcap[bn] = b_data;
                bn++;
            end
            if (b_fd) begin
                b_fd_cnt++;
                if (b_fs) b_coincide++;
                if (b_fd_cnt == 1) b_chk_next = 1;
            end
            @(posedge clock);
            #1;
            b_start = 1'b0;
        end
        chk("b_frame_done_cnt", 64'(b_fd_cnt), 64'd2);
        chk("b_done_start_coincide", 64'(b_coincide), 64'd2);
        chk("b_transfers", 64'(bn), 64'(2 * BN));
        chk("b_second_first_pixel", bcap[BN], 16'h1000);
        b_bad = 0;
        for (int i = 0; i < 2 * BN; i++) begin
            if (bcap[i] !== exp_b(i)) b_bad++;
        end
        chk("b_order", 64'(b_bad), 64'd0);

        // Reset mid-frame, asserted between clock edges
        repeat (10) @(posedge clock);
        #3;
        chk("b_midframe_busy", {b_busy, b_valid}, 2'b11);
        b_reset_n = 1'b0;
        #1;
        chk("b_async_reset", {b_x, b_y, b_data, b_valid, b_fs, b_fd, b_busy, b_ten}, 64'd0);
        @(posedge clock);
        #1;
        b_reset_n = 1'b1;
        b_fd_after = 0;
        b_busy_after = 0;
        repeat (50) begin
            @(negedge clock);
            if (b_fd) b_fd_after++;
            if (b_busy) b_busy_after = 1;
        end
        chk("b_no_done_after_abort", 64'(b_fd_after), 64'd0);
        chk("b_idle_after_abort", 64'(b_busy_after), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
